slt_sort_ctrl: RTL and testbench
================================

Name: slt_sort_ctrl

Overview:
- Sequential sorting controller that shares one signed less-than comparator (existing `slt`, N-bit, two's complement) across a small register bank.
- Accepts a burst of up to DEPTH signed words over a valid/ready stream, then bubble-sorts them in place, one compare per cycle.
- Streams the words out in ascending signed order.
- Serves as a reusable ordering engine (e.g. median/min-k selection) in front of the ALU datapath.

Parameters:
- N, 32, data word width in bits (signed, two's complement).
- DEPTH, 8, maximum number of words per burst (>= 2).
- CW, $clog2(DEPTH+1), width of the count/index registers.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  N  signed word to load.
- in_last  input  1  qualifies in_data as the final word of the burst.
- out_valid  output  1  out_data holds a sorted word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  N  sorted word, ascending signed order.
- out_last  output  1  qualifies out_data as the final word of the burst.
- busy  output  1  high in S_SORT and S_OUT.

Behaviour:
- Reset (asynchronous, any state):
  - state = S_LOAD; count, idx, pass and swapped cleared.
  - in_ready = 1; out_valid = 0; out_last = 0; busy = 0; out_data = 0.
  - Register bank contents are don't-care.
  - Reset mid-sort or mid-output discards the burst; no partial output follows.

- S_LOAD:
  - in_ready = 1.
  - A word transfers on in_valid & in_ready. It is written to bank[count], then count increments.
  - Transition to S_SORT when a word transfers with in_last = 1, or when count reaches DEPTH (in_last implied).
  - In_ready drops the cycle after the transition.
  - If the final count is 1, go straight to S_OUT; a single element skips sorting.

- S_SORT (one compare per cycle):
  - Comparator inputs: a = bank[idx+1], b = bank[idx].
  - If the comparator reports a < b (signed), swap the two entries at the clock edge and set swapped.
  - Equal values never swap, so the sort is stable.
  - idx runs 0 .. count-2. At idx = count-2 the pass ends:
    - If no swap occurred in the pass (including a swap on the final compare), go to S_OUT.
    - Otherwise, and if pass < count-1, clear swapped, reset idx to 0, increment pass.
    - A hard limit of count-1 passes forces S_OUT.
  - Cycle cost: (count-1) per pass.
    - Best case (pre-sorted input): count-1 cycles.
    - Worst case: (count-1)^2 cycles.
  - in_ready = 0 and out_valid = 0 throughout.

- S_OUT:
  - out_valid = 1; out_data = bank[idx], where idx is cleared on entry.
  - out_last = 1 when idx = count-1.
  - On out_valid & out_ready, idx increments.
  - When the last word is transferred: clear count, return to S_LOAD, in_ready = 1 on the next cycle.
  - out_data and out_last are held stable while out_ready = 0.
  - out_valid does not depend combinationally on out_ready.

- No overlap between phases: input is never accepted while busy. There is no simultaneous load/unload.
- Sign handling:
  - 0x8000_0000 sorts as the most negative value; 0x7FFF_FFFF as the most positive.
  - Overflow cases are handled by the comparator's sign-mismatch path.
- All registered outputs are driven from flops or the state decode only; no combinational path from in_valid to in_ready.

Decomposition:
- Shared package `sort_pkg`:
  - typedef enum logic [1:0] {S_LOAD, S_SORT, S_OUT} sort_state_t.
  - Default width/depth constants.
- One natural sub-module: the existing `slt` comparator, instantiated once with N passed through. Its inputs are muxed by idx.
- Register bank, counters and FSM stay in this module. The bank is a flop array, not RAM, because the swap needs a dual write.

Test Plan:
- Reverse order: load 5,4,3,2,1 with in_last on 1 → output 1,2,3,4,5; out_last only on 5; sort phase takes 16 cycles (4 passes x 4 compares).
- Signed extremes: load 0x00000001, 0xFFFFFFFF, 0x80000000, 0x7FFFFFFF, 0x00000000 → output 0x80000000, 0xFFFFFFFF, 0x00000000, 0x00000001, 0x7FFFFFFF.
- Full burst without in_last: 8 words 7,-3,7,0,-3,100,-100,2 → load closes at count 8; output -100,-3,-3,0,2,7,7,100; pre-sorted rerun shows sort phase = 7 cycles.
- Single word: load 42 with in_last → no S_SORT cycles; next cycle out_valid = 1, out_data = 42, out_last = 1.
- Backpressure: hold out_ready = 0 for 3 cycles mid-stream, then toggle it randomly → data is held stable while stalled, no drops or duplicates, in_ready stays 0 until the last transfer.
- Reset mid-sort: assert rst during pass 2 of a 6-word burst → outputs go to their reset values immediately; a new burst of 2,1 then yields 1,2.

Source files
------------

// File: rtl/sort_pkg.sv
// ============================================================================
// sort_pkg - shared state encoding and default sizing for slt_sort_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package sort_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SORT = 2'd1,
    S_OUT  = 2'd2
  } sort_state_t;

  localparam int SORT_N_DEFAULT     = 32;
  localparam int SORT_DEPTH_DEFAULT = 8;

endpackage

`default_nettype wire

// File: rtl/slt.sv
// ============================================================================
// slt - N-bit signed (two's complement) less-than comparator
// Rev 1.0
// ============================================================================
`default_nettype none

module slt #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         lt_o
);

  logic [N-1:0] w_diff;

  assign w_diff = a_i - b_i;
  // Differing signs: the negative operand is smaller and the subtraction
  // could overflow, so trust the sign bit of a directly.
  assign lt_o = (a_i[N-1] != b_i[N-1]) ? a_i[N-1] : w_diff[N-1];

endmodule

`default_nettype wire

// File: rtl/slt_sort_ctrl.sv
// ============================================================================
// slt_sort_ctrl - load a burst of signed words, bubble-sort in place with one
// shared comparator, stream them out in ascending order.
// Rev 1.0
// ============================================================================
`default_nettype none

module slt_sort_ctrl
  import sort_pkg::*;
#(
  parameter int N     = SORT_N_DEFAULT,
  parameter int DEPTH = SORT_DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TWO_C   = CW'(2);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  sort_state_t   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q,   idx_d;
  logic [CW-1:0] pass_q,  pass_d;
  logic          swapped_q, swapped_d;
  logic [N-1:0]  bank_q [DEPTH];

  logic [CW-1:0] w_count_nx;
  logic [CW-1:0] w_idx_nx;
  logic [AW-1:0] w_lo;
  logic [AW-1:0] w_hi;
  logic          w_lt;
  logic          w_pass_end;
  logic          w_last_out;

  assign w_count_nx = count_q + ONE_C;
  assign w_idx_nx   = idx_q + ONE_C;
  assign w_lo       = idx_q[AW-1:0];
  assign w_hi       = w_idx_nx[AW-1:0];
  assign w_pass_end = (idx_q == count_q - TWO_C);
  assign w_last_out = (idx_q == count_q - ONE_C);

  slt #(.N(N)) u_slt (
    .a_i  (bank_q[w_hi]),
    .b_i  (bank_q[w_lo]),
    .lt_o (w_lt)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    swapped_d = swapped_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          count_d = w_count_nx;
          if (in_last || (w_count_nx == DEPTH_C)) begin
            idx_d     = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
            state_d   = (w_count_nx == ONE_C) ? S_OUT : S_SORT;
          end
        end
      end
      S_SORT: begin
        if (w_lt) swapped_d = 1'b1;
        if (w_pass_end) begin
          idx_d = '0;
          // Another pass only if this one moved something and the
          // count-1 pass ceiling has not been reached.
          if ((swapped_q || w_lt) && (pass_q < count_q - TWO_C)) begin
            pass_d    = pass_q + ONE_C;
            swapped_d = 1'b0;
          end else begin
            state_d = S_OUT;
          end
        end else begin
          idx_d = w_idx_nx;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (w_last_out) begin
            state_d = S_LOAD;
            count_d = '0;
            idx_d   = '0;
          end else begin
            idx_d = w_idx_nx;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_LOAD);
    out_valid = (state_q == S_OUT);
    busy      = (state_q == S_SORT) || (state_q == S_OUT);
    out_last  = out_valid && w_last_out;
    out_data  = out_valid ? bank_q[w_lo] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LOAD;
      count_q   <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      swapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      swapped_q <= swapped_d;
    end
  end

  // Bank content is meaningless until loaded, so it carries no reset.
  always_ff @(posedge clk) begin
    if ((state_q == S_LOAD) && in_valid) begin
      bank_q[count_q[AW-1:0]] <= in_data;
    end else if ((state_q == S_SORT) && w_lt) begin
      bank_q[w_lo] <= bank_q[w_hi];
      bank_q[w_hi] <= bank_q[w_lo];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_slt_sort_ctrl.sv
// ============================================================================
// tb_slt_sort_ctrl - scoreboard bench for slt_sort_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_slt_sort_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          stim[8];
  int          sc;

  slt_sort_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic push_sorted(input int n);
    int t[8];
    int v;
    int j;
    for (int i = 0; i < n; i++) t[i] = stim[i];
    for (int i = 1; i < n; i++) begin
      v = t[i];
      j = i - 1;
      while (j >= 0 && t[j] > v) begin
        t[j+1] = t[j];
        j--;
      end
      t[j+1] = v;
    end
    for (int i = 0; i < n; i++) exp_q.push_back(t[i]);
  endtask

  task automatic send_burst(input int n, input bit with_last, input bit expect_out);
    if (expect_out) push_sorted(n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL load_ready word=%0d in_ready=%b expected=1", i, in_ready);
      end
      in_valid = 1'b1;
      in_data  = stim[i];
      in_last  = with_last && (i == n - 1);
    end
  endtask

  task automatic drain(input int n, input int mode, output int sort_cyc);
    int          got   = 0;
    int          cyc   = 0;
    int          oc    = 0;
    bit          first = 1'b1;
    bit          held  = 1'b0;
    bit          r;
    logic [31:0] hd;
    logic        hl;
    logic [31:0] e;
    sort_cyc = 0;
    while (got < n && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (first) begin
        first = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL ready_drop in_ready=%b expected=0", in_ready);
        end
      end
      if (busy === 1'b1 && out_valid !== 1'b1) sort_cyc++;
      if (out_valid === 1'b1) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL ready_in_out in_ready=%b expected=0", in_ready);
        end
        if (held) begin
          checks++;
          if (out_data !== hd || out_last !== hl) begin
            failures++;
            $display("FAIL stall_hold data=%h last=%b expected data=%h last=%b",
                     out_data, out_last, hd, hl);
          end
        end
        if (mode == 0) r = 1'b1;
        else if (oc < 2) r = 1'b1;
        else if (oc < 5) r = 1'b0;
        else r = 1'($urandom_range(0, 1));
        oc++;
        out_ready = r;
        if (r) begin
          held = 1'b0;
          got++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL extra_word data=%h expected=none", out_data);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
              failures++;
              $display("FAIL out_data idx=%0d data=%h expected=%h", got - 1, out_data, e);
            end
          end
          checks++;
          if (out_last !== (got == n)) begin
            failures++;
            $display("FAIL out_last idx=%0d last=%b expected=%b", got - 1, out_last, got == n);
          end
        end else begin
          held = 1'b1;
          hd   = out_data;
          hl   = out_last;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    if (got < n) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d expected=%0d", got, n);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after in_ready=%b busy=%b out_valid=%b expected 1,0,0",
               in_ready, busy, out_valid);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        busy !== 1'b0 || out_data !== 32'h0) begin
      failures++;
      $display("FAIL %s in_ready=%b out_valid=%b out_last=%b busy=%b out_data=%h expected 1,0,0,0,0",
               tag, in_ready, out_valid, out_last, busy, out_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reverse();
    stim = '{5, 4, 3, 2, 1, 0, 0, 0};
    send_burst(5, 1'b1, 1'b1);
    drain(5, 0, sc);
    checks++;
    if (sc !== 16) begin
      failures++;
      $display("FAIL reverse_sort_cycles got=%0d expected=16", sc);
    end
  endtask

  task automatic test_extremes();
    stim = '{1, -1, int'(32'h8000_0000), int'(32'h7FFF_FFFF), 0, 0, 0, 0};
    send_burst(5, 1'b1, 1'b1);
    drain(5, 0, sc);
  endtask

  task automatic test_full_burst();
    stim = '{7, -3, 7, 0, -3, 100, -100, 2};
    send_burst(8, 1'b0, 1'b1);
    drain(8, 0, sc);
    stim = '{-100, -3, -3, 0, 2, 7, 7, 100};
    send_burst(8, 1'b0, 1'b1);
    drain(8, 0, sc);
    checks++;
    if (sc !== 7) begin
      failures++;
      $display("FAIL presorted_sort_cycles got=%0d expected=7", sc);
    end
  endtask

  task automatic test_single();
    stim = '{42, 0, 0, 0, 0, 0, 0, 0};
    send_burst(1, 1'b1, 1'b1);
    drain(1, 0, sc);
    checks++;
    if (sc !== 0) begin
      failures++;
      $display("FAIL single_sort_cycles got=%0d expected=0", sc);
    end
  endtask

  task automatic test_backpressure();
    stim = '{9, -1, 4, 4, -8, 3, 0, 0};
    send_burst(6, 1'b1, 1'b1);
    drain(6, 1, sc);
  endtask

  task automatic test_reset_mid_sort();
    stim = '{6, 5, 4, 3, 2, 1, 0, 0};
    send_burst(6, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_sort_busy busy=%b out_valid=%b expected 1,0", busy, out_valid);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    stim = '{2, 1, 0, 0, 0, 0, 0, 0};
    send_burst(2, 1'b1, 1'b1);
    drain(2, 0, sc);
  endtask

  initial begin
    test_reset();
    test_reverse();
    test_extremes();
    test_full_burst();
    test_single();
    test_backpressure();
    test_reset_mid_sort();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected count=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
